servile_uart_tx_wb: RTL and testbench



---
 rtl/servile_uart_tx_wb.sv | 223 ++++++++++++++++++++++
 tb/tb_servile_uart_tx_wb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servile_uart_tx_wb.sv
// Wishbone UART transmitter for the servile extension bus: TX FIFO, 8N1 serializer, runtime divisor.
// Optional interrupt output and CTRL register at address 3 when SERVILE_UART_TX_IRQ_EN is defined.
module servile_uart_tx_wb #(
   parameter int clk_div    = 868,
   parameter int fifo_depth = 8
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_stb,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_tx
`ifdef SERVILE_UART_TX_IRQ_EN
   ,
   output logic        o_irq
`endif
);

   localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   typedef struct packed {
      logic [1:0]  rsel;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wb_req_t;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  level;
      logic [3:0]  rsvd_lo;
      logic        ovf;
      logic        empty;
      logic        full;
      logic        busy;
   } status_t;

   wb_req_t req;
   logic    acc, wr, rd;
   logic    push_req, push, pop, clr_ovf;

   assign req      = '{rsel: i_wb_adr[3:2], we: i_wb_we, dat: i_wb_dat, sel: i_wb_sel};
   assign acc      = i_wb_stb & ~o_wb_ack;
   assign wr       = acc & req.we;
   assign rd       = acc & ~req.we;
   assign push_req = wr & (req.rsel == 2'd0) & req.sel[0];
   assign clr_ovf  = wr & (req.rsel == 2'd1) & req.sel[0] & req.dat[3];

   // ---------------- TX FIFO ----------------
   logic [7:0]    mem [fifo_depth];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, ovf;

   assign full  = (count == (AW+1)'(fifo_depth));
   assign empty = (count == '0);
   // Fullness is judged on the pre-pop level, so a same-cycle pop cannot rescue a push.
   assign push  = push_req & ~full;

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= req.dat[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && full) ovf <= 1'b1;
         else if (clr_ovf)     ovf <= 1'b0;
      end
   end

   // ---------------- divisor ----------------
   logic [15:0] divisor, div_eff;

   assign div_eff = (divisor == 16'd0) ? 16'd1 : divisor;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         divisor <= 16'(clk_div);
      end else if (wr && req.rsel == 2'd2) begin
         if (req.sel[0]) divisor[7:0]  <= req.dat[7:0];
         if (req.sel[1]) divisor[15:8] <= req.dat[15:8];
      end
   end

   // ---------------- serializer ----------------
   state_t      state, nxt;
   logic [15:0] timer;
   logic [2:0]  idx;
   logic [7:0]  shreg;
   logic        tick, busy, line;

   assign tick = (timer == 16'd0);
   assign busy = (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt  = state;
      pop  = 1'b0;
      line = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               nxt = START;
            end
         end
         START: begin
            line = 1'b0;
            if (tick) nxt = DATA;
         end
         DATA: begin
            line = shreg[0];
            if (tick && idx == 3'd7) nxt = STOP;
         end
         STOP: begin
            if (tick) begin
               if (!empty) begin
                  pop = 1'b1;
                  nxt = START;
               end else begin
                  nxt = IDLE;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // The line is registered from the state, so it trails the pop by one clock.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         timer <= '0;
         idx   <= '0;
         shreg <= '0;
         o_tx  <= 1'b1;
      end else begin
         o_tx <= line;
         if (pop) begin
            shreg <= mem[rd_ptr];
            timer <= div_eff;
            idx   <= '0;
         end else if (busy) begin
            timer <= tick ? div_eff : timer - 16'd1;
            if (state == DATA && tick) begin
               shreg <= {1'b0, shreg[7:1]};
               idx   <= idx + 3'd1;
            end
         end
      end
   end

   // ---------------- optional interrupt ----------------
   logic ien;
`ifdef SERVILE_UART_TX_IRQ_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ien   <= 1'b0;
         o_irq <= 1'b0;
      end else begin
         if (wr && req.rsel == 2'd3 && req.sel[0]) ien <= req.dat[0];
         o_irq <= ien & empty & ~busy;
      end
   end
`else
   assign ien = 1'b0;
`endif

   // ---------------- bus response ----------------
   status_t     status;
   logic [31:0] rmux;

   always_comb begin
      status         = '0;
      status.level   = 8'(count);
      status.ovf     = ovf;
      status.empty   = empty;
      status.full    = full;
      status.busy    = busy;
      rmux           = 32'd0;
      case (req.rsel)
         2'd1:    rmux = status;
         2'd2:    rmux = {16'd0, divisor};
         2'd3:    rmux = {31'd0, ien};
         default: rmux = 32'd0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_wb_ack <= 1'b0;
         o_wb_rdt <= 32'd0;
      end else begin
         o_wb_ack <= acc;
         o_wb_rdt <= rd ? rmux : 32'd0;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{i_wb_adr[1:0], i_wb_dat[31:16], i_wb_sel[3:2]};

endmodule

// File: tb/tb_servile_uart_tx_wb.sv
// Randomized bench for servile_uart_tx_wb: frame-schedule model of the serial line and register file.
module tb_servile_uart_tx_wb;
   localparam int DEPTH = 8;
   localparam int NF    = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  adr = '0;
   logic [31:0] dat = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic        stb = 1'b0;
   logic [31:0] rdt;
   logic        ack;
   logic        tx;
`ifdef SERVILE_UART_TX_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   servile_uart_tx_wb #(.clk_div(868), .fifo_depth(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
      .i_wb_we(we), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_tx(tx)
`ifdef SERVILE_UART_TX_IRQ_EN
      , .o_irq(irq)
`endif
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Model: each accepted byte becomes a scheduled frame on the line.
   int          fr_start [NF];
   int          fr_end   [NF];
   int          fr_ack   [NF];
   int          fr_p     [NF];
   logic [7:0]  fr_byte  [NF];
   int          nfr = 0, base = 0, last_end = 0;
   logic [15:0] m_div = 16'd868;
   logic        m_ovf = 1'b0;
   logic        hist [65536];
   int          rx_cnt = 0, rx_left = 0;

   function automatic int m_p();
      return ((m_div == 16'd0) ? 1 : int'(m_div)) + 1;
   endfunction

   function automatic int m_level(input int r);
      int l = 0;
      for (int k = base; k < nfr; k++)
         if (fr_ack[k] <= r - 1 && fr_start[k] > r) l++;
      return l;
   endfunction

   function automatic logic m_busy(input int r);
      for (int k = base; k < nfr; k++)
         if (fr_start[k] <= r && r < fr_end[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_status(input int r);
      int l = m_level(r);
      return {16'h0, 8'(l), 4'h0, m_ovf, l == 0, l == DEPTH, m_busy(r)};
   endfunction

   always @(negedge clk) begin : cmp
      logic e;
      int   t;
      e = 1'b1;
      for (int k = 0; k < nfr; k++) begin
         if (cyc >= fr_start[k] && cyc < fr_end[k]) begin
            t = (cyc - fr_start[k]) / fr_p[k];
            e = (t == 0) ? 1'b0 : (t == 9) ? 1'b1 : fr_byte[k][t-1];
         end
      end
      chk("tx_line", {31'd0, tx}, {31'd0, e});
      hist[cyc & 16'hFFFF] = tx;
      if (!ack) chk("rdt_idle", rdt, 32'd0);
      if (rx_left > 0) rx_left--;
      else if (tx == 1'b0) begin
         rx_cnt++;
         rx_left = 10 * m_p() - 1;
      end
   end

   // Bus access: entered and left just after a rising edge.
   task automatic wb(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int ae);
      adr = {a, 2'b00}; dat = d; sel = s; we = w; stb = 1'b1;
      @(posedge clk); #1;
      chk("ack_rise", {31'd0, ack}, 32'd1);
      ae = cyc; r = rdt;
      stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("ack_fall", {31'd0, ack}, 32'd0);
   endtask

   task automatic push(input logic [7:0] b, output int ae);
      logic [31:0] r;
      int st;
      wb(1'b1, 2'd0, {24'h0, b}, 4'h1, r, ae);
      if (m_level(ae) == DEPTH) m_ovf = 1'b1;
      else if (nfr < NF) begin
         st = (ae + 2 > last_end) ? ae + 2 : last_end;
         fr_start[nfr] = st; fr_ack[nfr] = ae; fr_p[nfr] = m_p();
         fr_end[nfr] = st + 10 * m_p(); fr_byte[nfr] = b;
         last_end = fr_end[nfr];
         nfr++;
      end
   endtask

   task automatic rd_status(output logic [31:0] v);
      int ae;
      wb(1'b0, 2'd1, 32'd0, 4'hF, v, ae);
      chk("status", v, m_status(ae));
   endtask

   task automatic wr_status(input logic [31:0] d);
      logic [31:0] r;
      int ae;
      wb(1'b1, 2'd1, d, 4'h1, r, ae);
      if (d[3]) m_ovf = 1'b0;
   endtask

   task automatic wr_div(input logic [15:0] d, input logic [3:0] s);
      logic [31:0] r;
      int ae;
      wb(1'b1, 2'd2, {16'h0, d}, s, r, ae);
      if (s[0]) m_div[7:0]  = d[7:0];
      if (s[1]) m_div[15:8] = d[15:8];
   endtask

   task automatic rd_div(output logic [31:0] v);
      int ae;
      wb(1'b0, 2'd2, 32'd0, 4'hF, v, ae);
      chk("divisor", v, {16'h0, m_div});
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30000 && cyc < last_end + 1; i++) begin
         @(posedge clk); #1;
      end
      chk("idle_timeout", {31'd0, cyc >= last_end + 1}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < nfr; k++) begin
         if (fr_end[k] > cyc + 1)     fr_end[k]   = cyc + 1;
         if (fr_start[k] > fr_end[k]) fr_start[k] = fr_end[k];
      end
      base = nfr; last_end = 0; m_div = 16'd868; m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] v;
      logic [9:0]  pat1;
      logic [19:0] pat2;
      logic [3:0]  s4;
      int a, a1, rx0, nfr0, st, r;

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      rd_status(v); chk("rst_status_lit", v, 32'h4);
      rd_div(v);    chk("rst_div_lit", v, 32'd868);

      // Single frame, divisor 3
      wr_div(16'd3, 4'h3);
      push(8'hA5, a);
      wait_idle();
      pat1 = 10'b1_1010_0101_0;
      chk("pre_start", {31'd0, hist[(a + 1) & 16'hFFFF]}, 32'd1);
      for (int i = 0; i < 40; i++)
         chk("frame_a5", {31'd0, hist[(a + 2 + i) & 16'hFFFF]}, {31'd0, pat1[i/4]});
      rd_status(v); chk("post_frame_lit", v, 32'h4);

      // Back-to-back, divisor 1
      wr_div(16'd1, 4'h3);
      push(8'h00, a1);
      push(8'hFF, a);
      wait_idle();
      pat2 = 20'hFFA00;
      for (int i = 0; i < 40; i++)
         chk("b2b", {31'd0, hist[(a1 + 2 + i) & 16'hFFFF]}, {31'd0, pat2[i/2]});

      // Randomized traffic
      wr_div(16'd2, 4'h3);
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4: push(8'($urandom), a);
            5: rd_status(v);
            6: begin
               wb(1'b0, 2'd0, 32'd0, 4'hF, v, a); chk("rd_txdata", v, 32'd0);
`ifndef SERVILE_UART_TX_IRQ_EN
               wb(1'b0, 2'd3, 32'd0, 4'hF, v, a); chk("rd_adr3", v, 32'd0);
`endif
               rd_div(v);
            end
            7: begin
               wb(1'b1, 2'd0, 32'h55, 4'hE, v, a);
`ifndef SERVILE_UART_TX_IRQ_EN
               wb(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, v, a);
`endif
               if ($urandom_range(0, 1) == 1) wr_status(32'h8);
            end
            8: repeat ($urandom_range(1, 40)) begin @(posedge clk); #1; end
            default: begin
               if (cyc >= last_end) begin
                  s4 = 4'($urandom_range(1, 3));
                  wr_div(16'($urandom_range(0, 4)), s4);
               end
            end
         endcase
      end
      wait_idle();

      // Overflow
      wr_div(16'd100, 4'h3);
      wr_status(32'h8);
      rx0 = rx_cnt; nfr0 = nfr;
      for (int i = 0; i < DEPTH + 2; i++) push(8'($urandom), a);
      rd_status(v); chk("ovf_status_lit", v, 32'h80B);
      wr_status(32'h8);
      rd_status(v); chk("ovf_clear_lit", v, 32'h803);
      wait_idle();
      chk("ovf_model_frames", nfr - nfr0, 32'd9);
      chk("ovf_line_frames", rx_cnt - rx0, 32'd9);

      // Reset during data bit 3
      wr_div(16'd7, 4'h3);
      push(8'h5A, a);
      st = a + 2;
      while (cyc < st + 33) begin @(posedge clk); #1; end
      do_reset();
      chk("midrst_tx", {31'd0, tx}, 32'd1);
      rd_status(v); chk("midrst_status_lit", v, 32'h4);
      rd_div(v);    chk("midrst_div_lit", v, 32'd868);
      rx0 = rx_cnt;
      repeat (300) begin @(posedge clk); #1; end
      chk("midrst_no_frames", rx_cnt - rx0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
